ef_lfsr20_8_chk: RTL
====================

EF_LFSR20_8_CHK -- requirements
Module: ef_lfsr20_8_chk

Interface
REQ-001 Parameter LOCK_WORDS, default 4: consecutive error-free words required in VERIFY before lock.
REQ-002 Parameter LOSS_WORDS, default 4: consecutive errored words in LOCK that force loss of lock.
REQ-003 Parameter CNT_W, default 16: width of error and word counters.
REQ-004 i_clk  input  1  single clock, all state updates on rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-high.
REQ-006 i_en  input  1  word-valid; i_r is accepted on an edge where i_en=1.
REQ-007 i_r  input  8  received word from the 20-bit, K=8 dither LFSR (poly 1+x^3+x^20, word = state[8:1]).
REQ-008 i_clr  input  1  synchronous clear of o_err_cnt and o_word_cnt; does not affect lock state.
REQ-009 o_lock  output  1  checker locked to the sequence.
REQ-010 o_err  output  1  registered one-cycle pulse: last accepted word in LOCK had >=1 bit mismatch.
REQ-011 o_err_cnt  output  CNT_W  saturating count of mismatched bits accepted in LOCK.
REQ-012 o_word_cnt  output  CNT_W  saturating count of words accepted in LOCK.

Function
REQ-013 Step function S(q): q'[19:12]=q[7:0]^q[10:3]; q'[11:0]=q[19:8]; local 20-bit state m advances by S once per accepted word in VERIFY and LOCK.
REQ-014 States ACQ0, ACQ1, ACQ2, VERIFY, LOCK; transitions only on accepted words (i_en=1), except reset.
REQ-015 ACQ0 stores w0=i_r -> ACQ1; ACQ1 stores w1 -> ACQ2; ACQ2 uses w2=i_r.
REQ-016 Seed in ACQ2: s[8:1]=w0, s[16:9]=w1, s[19:17]=w2[2:0], s[0]=w2[3]^w0[2]; m <= S(S(S(s))).
REQ-017 Seed s=0 (lockup state) is invalid: ACQ2 -> ACQ0, m unchanged; otherwise ACQ2 -> VERIFY with good-run counter 0.
REQ-018 VERIFY/LOCK expected word = m[8:1]; mismatch vector = i_r ^ m[8:1].
REQ-019 VERIFY: error-free word increments good-run; errored word -> ACQ0; good-run reaching LOCK_WORDS -> LOCK (o_lock=1 next cycle).
REQ-020 LOCK: o_word_cnt += 1; o_err_cnt += popcount(mismatch); both saturate at 2^CNT_W-1, no wrap.
REQ-021 LOCK: errored word sets o_err for one cycle and increments bad-run; error-free word clears bad-run.
REQ-022 bad-run reaching LOSS_WORDS -> ACQ0, o_lock=0 next cycle; counters hold values.
REQ-023 m never resynchronizes in LOCK; it free-runs with accepted words regardless of errors.
REQ-024 i_en=0: no state, m, counter, or o_err change; o_err returns to 0.
REQ-025 i_clr with a simultaneous LOCK word: clear wins, counters load the current word's contribution (words=1, errors=popcount), saturation still applied.
REQ-026 Outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-027 i_rst=1 asynchronously forces ACQ0, m=0, w0/w1=0, run counters=0, o_lock=0, o_err=0, o_err_cnt=0, o_word_cnt=0.
REQ-028 Reset asserted mid-LOCK discards lock; after release, acquisition restarts from ACQ0 on the next accepted word.

Verification
REQ-029 Generator reset (state 0x00001), words 0x00,0x00,0x08,... fed continuously -> seed 0x00001, o_lock=1 after 3+4 accepted words, o_err_cnt=0.
REQ-030 Locked, one word with i_r = expected^0x81 -> o_err pulse 1 cycle, o_err_cnt +2, o_lock stays 1.
REQ-031 Locked, 4 consecutive words inverted -> o_lock=0 after 4th, o_err_cnt +32, state ACQ0; clean stream relocks after 7 words.
REQ-032 Words 0x00,0x00,0x00 during acquisition -> zero seed rejected, remains unlocked, restarts ACQ0.
REQ-033 CNT_W=4, locked, repeated inverted words with LOSS_WORDS=8 -> o_err_cnt saturates at 15; i_clr same cycle as errored word -> o_err_cnt=8, o_word_cnt=1.
REQ-034 i_en toggled randomly and i_rst pulsed mid-LOCK -> gaps ignored, reset clears all outputs asynchronously, relock follows REQ-029 timing.

Source files
------------

// File: rtl/ef_lfsr20_8_chk.sv
// ef_lfsr20_8_chk: lock/error checker for the 20-bit, 8-bit-word dither LFSR.
// Ports: i_clk, i_rst (async high), i_en word valid, i_r word, i_clr counter
//   clear; o_lock locked, o_err errored-word pulse, o_err_cnt bit errors,
//   o_word_cnt words seen while locked.
module ef_lfsr20_8_chk #(
  parameter int LOCK_WORDS = 4,
  parameter int LOSS_WORDS = 4,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [7:0]       i_r,
  input  logic             i_clr,
  output logic             o_lock,
  output logic             o_err,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_word_cnt
);

  localparam int GW = $clog2(LOCK_WORDS + 1);
  localparam int BW = $clog2(LOSS_WORDS + 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_WORDS - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(LOSS_WORDS - 1);

  typedef enum logic [2:0] {
    ACQ0, ACQ1, ACQ2, VERIFY, LOCK
  } st_t;

  // Eight LFSR shifts at once.
  function automatic logic [19:0] step(input logic [19:0] q);
    return {q[7:0] ^ q[10:3], q[19:8]};
  endfunction

  st_t st, st_nx;
  logic [19:0] m, m_nx;
  logic [7:0] w0, w0_nx, w1, w1_nx;
  logic [GW-1:0] good, good_nx;
  logic [BW-1:0] bad, bad_nx;
  logic lock_nx, err_nx;

  logic [19:0] seed;
  logic [7:0] mis;
  logic [3:0] pop;
  logic [CNT_W:0] e_sum, w_sum;

  // Word 2 exposes s[0] only mixed with s[3]; undo that with w0[2].
  assign seed = {i_r[2:0], w1, w0, i_r[3] ^ w0[2]};
  assign mis  = i_r ^ m[8:1];

  always_comb begin
    pop = '0;
    for (int i = 0; i < 8; i++)
      pop = pop + {3'b000, mis[i]};
  end

  always_comb begin
    st_nx   = st;
    m_nx    = m;
    w0_nx   = w0;
    w1_nx   = w1;
    good_nx = good;
    bad_nx  = bad;
    err_nx  = 1'b0;
    if (i_en) begin
      unique case (st)
        ACQ0: begin
          w0_nx = i_r;
          st_nx = ACQ1;
        end
        ACQ1: begin
          w1_nx = i_r;
          st_nx = ACQ2;
        end
        ACQ2: begin
          if (seed == '0) begin
            st_nx = ACQ0;
          end else begin
            // Seed is the state of word 0; three steps reach word 3.
            m_nx    = step(step(step(seed)));
            good_nx = '0;
            st_nx   = VERIFY;
          end
        end
        VERIFY: begin
          m_nx = step(m);
          if (|mis) begin
            st_nx = ACQ0;
          end else if (good == GOOD_LAST) begin
            bad_nx = '0;
            st_nx  = LOCK;
          end else begin
            good_nx = good + GW'(1);
          end
        end
        LOCK: begin
          m_nx   = step(m);
          err_nx = |mis;
          if (!(|mis)) begin
            bad_nx = '0;
          end else if (bad == BAD_LAST) begin
            bad_nx = '0;
            st_nx  = ACQ0;
          end else begin
            bad_nx = bad + BW'(1);
          end
        end
        default: st_nx = ACQ0;
      endcase
    end
    lock_nx = (st_nx == LOCK);
  end

  // Extra top bit catches overflow for saturation.
  always_comb begin
    e_sum = i_clr ? '0 : {1'b0, o_err_cnt};
    w_sum = i_clr ? '0 : {1'b0, o_word_cnt};
    if (i_en && st == LOCK) begin
      e_sum = e_sum + (CNT_W+1)'(pop);
      w_sum = w_sum + (CNT_W+1)'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st         <= ACQ0;
      m          <= '0;
      w0         <= '0;
      w1         <= '0;
      good       <= '0;
      bad        <= '0;
      o_lock     <= 1'b0;
      o_err      <= 1'b0;
      o_err_cnt  <= '0;
      o_word_cnt <= '0;
    end else begin
      st         <= st_nx;
      m          <= m_nx;
      w0         <= w0_nx;
      w1         <= w1_nx;
      good       <= good_nx;
      bad        <= bad_nx;
      o_lock     <= lock_nx;
      o_err      <= err_nx;
      o_err_cnt  <= e_sum[CNT_W] ? '1 : e_sum[CNT_W-1:0];
      o_word_cnt <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
    end
  end

endmodule
